// File: rtl/clkgen_pkg.sv
// clkgen_pkg: state encoding, per-channel config type and config clamping for clkgen_multi.
package clkgen_pkg;

   typedef enum logic [1:0] {ALIGN, WARM, LOCK} state_t;

   // Fields are 32 bits wide so that one type serves any CNT_W up to 32.
   typedef struct packed {
      logic [31:0] div;
      logic [31:0] phase;
   } chan_cfg_t;

   function automatic chan_cfg_t clamp_cfg(input chan_cfg_t c);
      chan_cfg_t r;
      r.div   = (c.div == '0) ? 32'd1 : c.div;
      r.phase = (c.phase >= r.div) ? r.div - 32'd1 : c.phase;
      return r;
   endfunction

endpackage

// File: rtl/clkgen_channel.sv
// clkgen_channel: one divider slice; phase delay, then a 0..div-1 counter driving registered outclk/clk_en.
module clkgen_channel #(
   parameter int CNT_W = 16
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [CNT_W-1:0] div,
   input  logic [CNT_W-1:0] phase,
   output logic             outclk,
   output logic             clk_en
);

   logic [CNT_W-1:0] cnt, ph_cnt;

   always_ff @(posedge refclk or negedge rst_n)
      if (!rst_n) begin
         cnt    <= '0;
         ph_cnt <= '0;
         outclk <= 1'b0;
         clk_en <= 1'b0;
      end else if (!run) begin
         cnt    <= '0;
         ph_cnt <= phase;
         outclk <= 1'b0;
         clk_en <= 1'b0;
      end else if (ph_cnt != '0) begin
         ph_cnt <= ph_cnt - CNT_W'(1);
         outclk <= 1'b0;
         clk_en <= 1'b0;
      end else begin
         clk_en <= cnt == '0;
         outclk <= cnt < div - (div >> 1);
         cnt    <= (cnt == div - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);
      end

endmodule

// File: rtl/clkgen_multi.sv
// clkgen_multi: NUM_CLK soft divided clocks with phase offsets and lock indication.
// Define CLKGEN_DYN_CFG_EN to enable runtime reconfiguration through the cfg_* port.
module clkgen_multi
   import clkgen_pkg::*;
#(
   parameter int                         NUM_CLK     = 4,
   parameter int                         CNT_W       = 16,
   parameter logic [NUM_CLK*CNT_W-1:0]   DIV_INIT    = {NUM_CLK{CNT_W'(2)}},
   parameter logic [NUM_CLK*CNT_W-1:0]   PHASE_INIT  = '0,
   parameter int                         LOCK_CYCLES = 16
) (
   input  logic                                         refclk,
   input  logic                                         rst_n,
   output logic [NUM_CLK-1:0]                           outclk,
   output logic [NUM_CLK-1:0]                           clk_en,
   output logic                                         locked,
   input  logic                                         cfg_valid,
   output logic                                         cfg_ready,
   input  logic [(NUM_CLK > 1 ? $clog2(NUM_CLK) : 1)-1:0] cfg_sel,
   input  logic [CNT_W-1:0]                             cfg_div,
   input  logic [CNT_W-1:0]                             cfg_phase,
   input  logic                                         cfg_apply
);

   localparam int LW = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [LW-1:0] WARM_LAST = LW'(LOCK_CYCLES - 1);

   state_t        state, state_nxt;
   logic [LW-1:0] warm_cnt;
   logic          apply;

`ifdef CLKGEN_DYN_CFG_EN
   assign cfg_ready = state != ALIGN;
   assign apply     = cfg_apply && cfg_ready;
`else
   logic unused_cfg;
   assign unused_cfg = ^{cfg_valid, cfg_sel, cfg_div, cfg_phase, cfg_apply};
   assign cfg_ready  = 1'b0;
   assign apply      = 1'b0;
`endif

   assign locked = state == LOCK;

   always_ff @(posedge refclk or negedge rst_n)
      if (!rst_n) begin
         state    <= ALIGN;
         warm_cnt <= '0;
      end else begin
         state    <= state_nxt;
         warm_cnt <= (state == WARM) ? warm_cnt + 1'b1 : '0;
      end

   always_comb begin
      state_nxt = apply ? ALIGN :
                  (state == ALIGN) ? WARM :
                  (state == WARM && warm_cnt == WARM_LAST) ? LOCK : state;
   end

   for (genvar i = 0; i < NUM_CLK; i++) begin : g_ch
      localparam chan_cfg_t INIT_C = clamp_cfg(chan_cfg_t'{div: 32'(DIV_INIT[i*CNT_W +: CNT_W]),
                                                          phase: 32'(PHASE_INIT[i*CNT_W +: CNT_W])});
      logic [CNT_W-1:0] act_div, act_ph;
`ifdef CLKGEN_DYN_CFG_EN
      logic [CNT_W-1:0] sh_div, sh_ph, wr_div, wr_ph;
      chan_cfg_t        new_c;
      logic             wr, unused_hi;
      // Write merges into the shadow before apply samples it, so a same-cycle write is committed.
      assign wr        = cfg_valid && cfg_ready && int'(cfg_sel) == i;
      assign wr_div    = wr ? cfg_div : sh_div;
      assign wr_ph     = wr ? cfg_phase : sh_ph;
      assign new_c     = clamp_cfg(chan_cfg_t'{div: 32'(wr_div), phase: 32'(wr_ph)});
      assign unused_hi = ^new_c;
      always_ff @(posedge refclk or negedge rst_n)
         if (!rst_n) begin
            sh_div  <= DIV_INIT[i*CNT_W +: CNT_W];
            sh_ph   <= PHASE_INIT[i*CNT_W +: CNT_W];
            act_div <= CNT_W'(INIT_C.div);
            act_ph  <= CNT_W'(INIT_C.phase);
         end else begin
            sh_div <= wr_div;
            sh_ph  <= wr_ph;
            if (apply) begin
               act_div <= CNT_W'(new_c.div);
               act_ph  <= CNT_W'(new_c.phase);
            end
         end
`else
      assign act_div = CNT_W'(INIT_C.div);
      assign act_ph  = CNT_W'(INIT_C.phase);
`endif
      clkgen_channel #(.CNT_W(CNT_W)) u_ch (
         .refclk (refclk),
         .rst_n  (rst_n),
         .run    (state != ALIGN),
         .div    (act_div),
         .phase  (act_ph),
         .outclk (outclk[i]),
         .clk_en (clk_en[i])
      );
   end

endmodule

// File: tb/tb_clkgen_multi.sv
// tb_clkgen_multi: directed checks of two clkgen_multi instances (A: D={4,3,0}, B: D/P mixes incl. P clamp).
module tb_clkgen_multi;

`ifdef CLKGEN_DYN_CFG_EN
   localparam bit DYN = 1'b1;
`else
   localparam bit DYN = 1'b0;
`endif

   logic        refclk = 1'b0, rst_n = 1'b0;
   logic        cfg_valid = 1'b0, cfg_apply = 1'b0;
   logic [1:0]  cfg_sel = '0;
   logic [15:0] cfg_div = '0, cfg_phase = '0;
   logic [2:0]  a_out, a_en;
   logic        a_lk, a_rdy;
   logic [3:0]  b_out, b_en;
   logic        b_lk, b_rdy;
   int          checks = 0, errors = 0, cyc = 0;

   typedef struct {
      int         k;
      logic [2:0] out;
      logic [2:0] en;
      logic       lk;
   } vec_t;
   vec_t tbl [11];

   always #5 refclk = ~refclk;

   clkgen_multi #(
      .NUM_CLK(3), .CNT_W(16), .DIV_INIT({16'd0, 16'd3, 16'd4}), .PHASE_INIT('0), .LOCK_CYCLES(16)
   ) dut_a (
      .refclk(refclk), .rst_n(rst_n), .outclk(a_out), .clk_en(a_en), .locked(a_lk),
      .cfg_valid(cfg_valid), .cfg_ready(a_rdy), .cfg_sel(cfg_sel), .cfg_div(cfg_div),
      .cfg_phase(cfg_phase), .cfg_apply(cfg_apply)
   );

   clkgen_multi #(
      .NUM_CLK(4), .CNT_W(16), .DIV_INIT({16'd1, 16'd4, 16'd8, 16'd8}),
      .PHASE_INIT({16'd0, 16'd9, 16'd3, 16'd0}), .LOCK_CYCLES(16)
   ) dut_b (
      .refclk(refclk), .rst_n(rst_n), .outclk(b_out), .clk_en(b_en), .locked(b_lk),
      .cfg_valid(1'b0), .cfg_ready(b_rdy), .cfg_sel(2'd0), .cfg_div(16'd0),
      .cfg_phase(16'd0), .cfg_apply(1'b0)
   );

   // Expected {outclk, clk_en} of a channel k edges after leaving reset/ALIGN (d, p already clamped).
   function automatic logic [1:0] exp_ch(input int k, input int d, input int p);
      int s = p + 2;
      int m;
      if (k < s) return 2'b00;
      m = (k - s) % d;
      return {m < d - d / 2, m == 0};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      @(negedge refclk);
      cyc++;
   endtask

   task automatic chk_a(input string nm, input int d0, input int d1);
      logic [1:0] c0, c1, c2;
      c0 = exp_ch(cyc, d0, 0);
      c1 = exp_ch(cyc, d1, 0);
      c2 = exp_ch(cyc, 1, 0);
      chk(nm, 32'({a_out, a_en, a_lk, a_rdy}),
          32'({c2[1], c1[1], c0[1], c2[0], c1[0], c0[0], cyc >= 17, DYN && cyc >= 1}));
   endtask

   task automatic chk_b();
      logic [1:0] c0, c1, c2, c3;
      c0 = exp_ch(cyc, 8, 0);
      c1 = exp_ch(cyc, 8, 3);
      c2 = exp_ch(cyc, 4, 3);
      c3 = exp_ch(cyc, 1, 0);
      chk("b_phase", 32'({b_out, b_en, b_lk}),
          32'({c3[1], c2[1], c1[1], c0[1], c3[0], c2[0], c1[0], c0[0], cyc >= 17}));
   endtask

   task automatic run_table();
      for (int i = 0; i < 11; i++) begin
         while (cyc < tbl[i].k) tick();
         chk("tbl", 32'({a_out, a_en, a_lk, a_rdy}),
             32'({tbl[i].out, tbl[i].en, tbl[i].lk, DYN && tbl[i].k >= 1}));
      end
   endtask

   initial begin
      tbl = '{'{0,  3'b000, 3'b000, 1'b0}, '{1,  3'b000, 3'b000, 1'b0},
              '{2,  3'b111, 3'b111, 1'b0}, '{3,  3'b111, 3'b100, 1'b0},
              '{4,  3'b100, 3'b100, 1'b0}, '{5,  3'b110, 3'b110, 1'b0},
              '{6,  3'b111, 3'b101, 1'b0}, '{7,  3'b101, 3'b100, 1'b0},
              '{16, 3'b100, 3'b100, 1'b0}, '{17, 3'b110, 3'b110, 1'b1},
              '{18, 3'b111, 3'b101, 1'b1}};
      repeat (3) @(negedge refclk);
      chk("rst_a", 32'({a_out, a_en, a_lk, a_rdy}), 32'd0);
      chk("rst_b", 32'({b_out, b_en, b_lk, b_rdy}), 32'd0);
      rst_n = 1'b1;
      cyc = 0;
      run_table();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_a", 32'({a_out, a_en, a_lk, a_rdy}), 32'd0);
      chk("async_rst_b", 32'({b_out, b_en, b_lk, b_rdy}), 32'd0);
      #1 rst_n = 1'b1;
      cyc = 0;
      run_table();
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      cyc = 0;
      while (cyc < 805) begin
         tick();
         chk_b();
      end
`ifdef CLKGEN_DYN_CFG_EN
      cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = 16'd6; cfg_phase = 16'd0;
      chk("ready_lock", 32'(a_rdy), 32'd1);
      tick();
      cfg_valid = 1'b0; cfg_apply = 1'b1;
      chk("lock_pre_apply", 32'(a_lk), 32'd1);
      tick();
      cfg_apply = 1'b0;
      cyc = 0;
      chk("apply_align", 32'({a_lk, a_rdy}), 32'd0);
      while (cyc < 20) begin
         tick();
         chk_a("apply_d6", 6, 3);
      end
      cfg_valid = 1'b1; cfg_sel = 2'd1; cfg_div = 16'd5; cfg_apply = 1'b1;
      tick();
      cfg_valid = 1'b0; cfg_apply = 1'b0;
      cyc = 0;
      chk("wr_apply_align", 32'({a_lk, a_rdy}), 32'd0);
      while (cyc < 20) begin
         tick();
         chk_a("same_cycle_d5", 6, 5);
      end
      cfg_valid = 1'b1; cfg_sel = 2'd3; cfg_div = 16'd2; cfg_apply = 1'b1;
      tick();
      cfg_valid = 1'b0; cfg_apply = 1'b0;
      cyc = 0;
      while (cyc < 12) begin
         tick();
         chk_a("sel_oob", 6, 5);
      end
`else
      cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = 16'd6; cfg_apply = 1'b1;
      repeat (12) begin
         tick();
         chk_a("cfg_ignored", 4, 3);
      end
      cfg_valid = 1'b0; cfg_apply = 1'b0;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
